// File: rtl/single_port_ram.sv
// Synchronous single-port RAM: shared address, separate write/read enables,
// registered read port with a one-cycle valid strobe. Contents clear on reset.
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;

    // Read uses mem_q (pre-write contents), giving read-before-write on collisions.
    always_comb begin
        mem_d      = mem_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        if (re) begin
            data_out_d = mem_q[addr];
            rd_valid_d = 1'b1;
        end
        if (we) begin
            mem_d[addr] = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Directed and randomised checks of single_port_ram against hand-computed
// values and a reference array model.
module tb_single_port_ram;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          rd_valid;

    int n_checks;
    int n_fail;

    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_dout;
    logic          exp_vld;

    single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held 2 cycles while a write is requested; it must be ignored.
        rst_n = 1'b0; we = 1'b1; re = 1'b0; addr = 6'd5; data_in = 8'hAA;
        step();
        step();
        chk("reset_dout", {24'd0, data_out}, 32'h00);
        chk("reset_vld", {31'd0, rd_valid}, 32'h0);

        rst_n = 1'b1; we = 1'b0; re = 1'b1; addr = 6'd5;
        step();
        chk("post_reset_rd5", {24'd0, data_out}, 32'h00);
        chk("post_reset_vld", {31'd0, rd_valid}, 32'h1);

        // Basic write then read.
        we = 1'b1; re = 1'b0; addr = 6'd10; data_in = 8'h3C;
        step();
        chk("write_only_vld", {31'd0, rd_valid}, 32'h0);
        we = 1'b0; re = 1'b1; addr = 6'd10;
        step();
        chk("rd10_dout", {24'd0, data_out}, 32'h3C);
        chk("rd10_vld", {31'd0, rd_valid}, 32'h1);
        re = 1'b0; addr = 6'd0;
        step();
        chk("idle_hold_dout", {24'd0, data_out}, 32'h3C);
        chk("idle_vld", {31'd0, rd_valid}, 32'h0);

        // Full sweep: every address, including both ends.
        for (int i = 0; i < 64; i++) begin
            we = 1'b1; re = 1'b0; addr = AW'(i); data_in = DW'(i) ^ 8'h5A;
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 64; i++) begin
            re = 1'b1; addr = AW'(i);
            step();
            chk($sformatf("sweep_rd%0d", i), {24'd0, data_out}, {24'd0, DW'(i) ^ 8'h5A});
            chk($sformatf("sweep_vld%0d", i), {31'd0, rd_valid}, 32'h1);
        end
        re = 1'b0;
        step();

        // Simultaneous read and write at one address: old data out, write lands.
        we = 1'b1; addr = 6'd7; data_in = 8'h11;
        step();
        we = 1'b1; re = 1'b1; addr = 6'd7; data_in = 8'h22;
        step();
        chk("rw_same_old", {24'd0, data_out}, 32'h11);
        chk("rw_same_vld", {31'd0, rd_valid}, 32'h1);
        we = 1'b0; re = 1'b1;
        step();
        chk("rw_same_new", {24'd0, data_out}, 32'h22);

        // Reset in the middle of a read discards it and clears the array.
        we = 1'b1; re = 1'b0; addr = 6'd3; data_in = 8'hF0;
        step();
        rst_n = 1'b0; we = 1'b0; re = 1'b1; addr = 6'd3;
        step();
        chk("midrst_dout", {24'd0, data_out}, 32'h00);
        chk("midrst_vld", {31'd0, rd_valid}, 32'h0);
        rst_n = 1'b1; re = 1'b1; addr = 6'd3;
        step();
        chk("midrst_rd3", {24'd0, data_out}, 32'h00);
        chk("midrst_rd3_vld", {31'd0, rd_valid}, 32'h1);
        re = 1'b1; addr = 6'd63;
        step();
        chk("midrst_rd63", {24'd0, data_out}, 32'h00);

        // Randomised traffic against a reference model, starting from a clean reset.
        rst_n = 1'b0; we = 1'b0; re = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        exp_dout = '0;
        exp_vld  = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            we      = 1'($urandom_range(0, 1));
            re      = 1'($urandom_range(0, 1));
            addr    = AW'($urandom_range(0, 63));
            data_in = DW'($urandom_range(0, 255));
            step();
            exp_vld = re;
            if (re) exp_dout = ref_mem[addr];
            if (we) ref_mem[addr] = data_in;
            chk("rand_vld", {31'd0, rd_valid}, {31'd0, exp_vld});
            chk("rand_dout", {24'd0, data_out}, {24'd0, exp_dout});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
